// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA operand bit-length scanner.
//   scan_state_e : FSM encoding for the scanner (IDLE -> SCAN -> DONE).
//   clog2()      : ceiling log2, usable in parameter/localparam expressions.
package rsa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rsa_word_bitlen.sv
// Combinational used-bit length of one WORD_W slice.
//   iW   : slice to measure
//   oLen : index of highest set bit + 1 (0 for an all-zero slice)
// Each prefix bit pre[i] is the OR of iW[WORD_W-1:i]; the bit length is then
// simply the number of ones in that prefix vector.
module rsa_word_bitlen
  import rsa_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  localparam int unsigned LW    = clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] iW,
  output logic [LW-1:0]     oLen
);

  logic [WORD_W-1:0] pre;

  always_comb begin
    for (int unsigned i = 0; i < WORD_W; i++) begin
      pre[i] = |(iW >> i);
    end
  end

  always_comb begin
    oLen = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      oLen = oLen + LW'(pre[i]);
    end
  end

endmodule

// File: rtl/rsa_bitlen_scan.sv
// Iterative scanner over a wide RSA operand, one WORD_W slice per cycle.
//   iClk, iRstn : clock, synchronous active-low reset
//   iStart      : start request, taken only in IDLE
//   iMode       : 0 = used-bit length, 1 = trailing-zero count (latched)
//   iD          : operand (latched with iStart)
//   oBusy       : scan in progress
//   oDone       : one-cycle pulse when oD/oZero have been updated
//   oD          : result, held until the next completed scan
//   oZero       : operand was all-zero, held like oD
// The operand is held in a shift register that moves toward the examined end
// (MSB side in mode 0, LSB side in mode 1), so only one fixed slice is ever
// inspected and no wide word mux is needed.
module rsa_bitlen_scan
  import rsa_pkg::*;
#(
  parameter  int unsigned DATA_W = 1024,
  parameter  int unsigned WORD_W = 32,
  localparam int unsigned CNT_W  = clog2(DATA_W + 1)
) (
  input  logic              iClk,
  input  logic              iRstn,
  input  logic              iStart,
  input  logic              iMode,
  input  logic [DATA_W-1:0] iD,
  output logic              oBusy,
  output logic              oDone,
  output logic [CNT_W-1:0]  oD,
  output logic              oZero
);

  localparam int unsigned NWORDS = DATA_W / WORD_W;
  localparam int unsigned JW     = (NWORDS > 1) ? clog2(NWORDS) : 1;
  localparam int unsigned SH     = clog2(WORD_W);
  localparam int unsigned LW     = clog2(WORD_W + 1);

  scan_state_e       state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [JW-1:0]     j_q, j_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  d_q, d_d;
  logic              zero_q, zero_d;

  logic [WORD_W-1:0] w, w_rev, w_meas;
  logic [LW-1:0]     bl;
  logic [CNT_W-1:0]  off, res;
  logic              last;

  always_comb begin
    w = mode_q ? sh_q[WORD_W-1:0] : sh_q[DATA_W-1 -: WORD_W];
    for (int unsigned i = 0; i < WORD_W; i++) begin
      w_rev[i] = w[WORD_W-1-i];
    end
    w_meas = mode_q ? w_rev : w;
  end

  rsa_word_bitlen #(.WORD_W(WORD_W)) u_bitlen (
    .iW   (w_meas),
    .oLen (bl)
  );

  // j*WORD_W by concatenation; both terms fit in CNT_W, so no overflow.
  always_comb begin
    off  = CNT_W'({j_q, {SH{1'b0}}});
    last = mode_q ? (j_q == JW'(NWORDS - 1)) : (j_q == '0);
    if (mode_q) begin
      res = off + CNT_W'(LW'(WORD_W) - bl);
    end else begin
      res = off + CNT_W'(bl);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      j_q     <= '0;
      mode_q  <= 1'b0;
      d_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      j_q     <= j_d;
      mode_q  <= mode_d;
      d_q     <= d_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    j_d     = j_q;
    mode_d  = mode_q;
    d_d     = d_q;
    zero_d  = zero_q;
    oBusy   = 1'b0;
    oDone   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          sh_d    = iD;
          mode_d  = iMode;
          j_d     = iMode ? '0 : JW'(NWORDS - 1);
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        oBusy = 1'b1;
        if ((w != '0) || last) begin
          // An all-zero operand needs no special result path: the formula on
          // the last word yields 0 (mode 0) or DATA_W (mode 1) by itself.
          d_d     = res;
          zero_d  = (w == '0);
          state_d = S_DONE;
        end else begin
          if (mode_q) begin
            sh_d = sh_q >> WORD_W;
            j_d  = j_q + JW'(1);
          end else begin
            sh_d = sh_q << WORD_W;
            j_d  = j_q - JW'(1);
          end
        end
      end
      S_DONE: begin
        oDone   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oD    = d_q;
  assign oZero = zero_q;

endmodule

// File: tb/tb_rsa_bitlen_scan.sv
module tb_rsa_bitlen_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // 1024/32 instance
  logic          s_b, m_b, busy_b, done_b, zero_b;
  logic [1023:0] d_b;
  logic [10:0]   od_b;

  // 64/16 instance
  logic          s_s, m_s, busy_s, done_s, zero_s;
  logic [63:0]   d_s;
  logic [6:0]    od_s;

  int checks = 0;
  int errors = 0;

  rsa_bitlen_scan #(.DATA_W(1024), .WORD_W(32)) u_big (
    .iClk(clk), .iRstn(rstn), .iStart(s_b), .iMode(m_b), .iD(d_b),
    .oBusy(busy_b), .oDone(done_b), .oD(od_b), .oZero(zero_b)
  );

  rsa_bitlen_scan #(.DATA_W(64), .WORD_W(16)) u_small (
    .iClk(clk), .iRstn(rstn), .iStart(s_s), .iMode(m_s), .iD(d_s),
    .oBusy(busy_s), .oDone(done_s), .oD(od_s), .oZero(zero_s)
  );

  function automatic void chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endfunction

  // Latency = posedges from the one that samples iStart's cycle end up to the
  // one after which oDone is visible (k+1 for k examined words).
  task automatic run_big(input string tag, input logic [1023:0] d, input logic m,
                         input int exp_d, input logic exp_z, input int exp_lat);
    int   lat;
    logic seen_busy;
    seen_busy = 1'b0;
    @(posedge clk); #1;
    s_b = 1'b1; d_b = d; m_b = m; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        s_b = 1'b0; d_b = ~d; m_b = ~m;
        seen_busy = busy_b;
      end
    end while (!done_b && lat < 100);
    chk({tag, " busy"}, int'(seen_busy), 1);
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " oD"}, int'(od_b), exp_d);
    chk({tag, " oZero"}, int'(zero_b), int'(exp_z));
    chk({tag, " busy@done"}, int'(busy_b), 0);
  endtask

  // Bit-serial reference for the 64/16 instance.
  function automatic void model(input logic [63:0] d, input logic m,
                                output int od, output int z, output int lat);
    od = m ? 64 : 0; z = 1; lat = 5;
    if (!m) begin
      for (int i = 63; i >= 0; i--) begin
        if (d[i] && z == 1) begin od = i + 1; z = 0; lat = 4 - i / 16 + 1; end
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (d[i] && z == 1) begin od = i; z = 0; lat = i / 16 + 2; end
      end
    end
  endfunction

  task automatic run_small(input logic [63:0] d, input logic m);
    int lat, eod, ez, elat;
    model(d, m, eod, ez, elat);
    @(posedge clk); #1;
    s_s = 1'b1; d_s = d; m_s = m; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin s_s = 1'b0; d_s = $urandom; end
    end while (!done_s && lat < 50);
    chk("rnd lat", lat, elat);
    chk("rnd oD", int'(od_s), eod);
    chk("rnd oZero", int'(zero_s), ez);
  endtask

  initial begin
    logic [1023:0] v;
    logic [63:0]   r;
    int            lat, ndone;

    rstn = 1'b0; s_b = 1'b0; m_b = 1'b0; d_b = '0;
    s_s = 1'b0; m_s = 1'b0; d_s = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", int'(busy_b), 0);
    chk("rst done", int'(done_b), 0);
    chk("rst oD", int'(od_b), 0);
    chk("rst oZero", int'(zero_b), 0);
    rstn = 1'b1;

    run_big("msb",   1024'(1) << 1023,                 1'b0, 1024, 1'b0, 2);
    run_big("one",   1024'(1),                         1'b0, 1,    1'b0, 33);
    run_big("w1",    1024'(32'h8000_0001) << 32,       1'b0, 64,   1'b0, 32);
    run_big("z0",    '0,                               1'b0, 0,    1'b1, 33);
    run_big("z1",    '0,                               1'b1, 1024, 1'b1, 33);
    run_big("tz100", 1024'(32'h100),                   1'b1, 8,    1'b0, 2);
    run_big("tz1000", 1024'(1) << 1000,                1'b1, 1000, 1'b0, 33);
    run_big("ones1", '1,                               1'b1, 0,    1'b0, 2);
    run_big("ones0", '1,                               1'b0, 1024, 1'b0, 2);

    // Re-pulse of iStart mid-scan with a different operand and mode.
    @(posedge clk); #1;
    s_b = 1'b1; d_b = 1024'(1); m_b = 1'b0; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin s_b = 1'b0; d_b = 1024'(1) << 1023; end
      if (lat == 4) begin s_b = 1'b1; m_b = 1'b1; end
      if (lat == 5) s_b = 1'b0;
    end while (!done_b && lat < 100);
    chk("repulse lat", lat, 33);
    chk("repulse oD", int'(od_b), 1);
    chk("repulse oZero", int'(zero_b), 0);

    // Reset in the middle of a scan: aborts, clears result, no oDone.
    @(posedge clk); #1;
    s_b = 1'b1; d_b = 1024'(1); m_b = 1'b0;
    @(posedge clk); #1;
    s_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-rst busy", int'(busy_b), 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("midrst busy", int'(busy_b), 0);
    chk("midrst done", int'(done_b), 0);
    chk("midrst oD", int'(od_b), 0);
    chk("midrst oZero", int'(zero_b), 0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_b) ndone++;
    end
    chk("midrst no done", ndone, 0);

    // iStart during the DONE cycle is dropped.
    run_big("dn", 1024'(32'h100), 1'b1, 8, 1'b0, 2);
    s_b = 1'b1; d_b = 1024'(1) << 1023; m_b = 1'b0;
    @(posedge clk); #1;
    s_b = 1'b0;
    chk("dn-start busy", int'(busy_b), 0);
    ndone = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done_b || busy_b) ndone++;
    end
    chk("dn-start idle", ndone, 0);
    chk("dn-start oD", int'(od_b), 8);

    // Small configuration: directed corner patterns then randomised ones.
    run_small(64'h0, 1'b0);
    run_small(64'h0, 1'b1);
    run_small(64'h8000_0000_0000_0000, 1'b0);
    run_small(64'h8000_0000_0000_0000, 1'b1);
    run_small(64'h0000_0001_0000_0000, 1'b1);
    for (int unsigned n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0: r = {$urandom, $urandom};
        1: r = 64'(1) << $urandom_range(0, 63);
        2: begin
          r = {$urandom, $urandom};
          for (int unsigned q = 0; q < 4; q++) begin
            if ($urandom_range(0, 1) == 1) r = r & ~(64'hFFFF << (16 * q));
          end
        end
        default: r = ($urandom_range(0, 1) == 1) ? '1 : '0;
      endcase
      run_small(r, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
